// File: rtl/fc_frame_ctrl.sv
// Frame sequencer for the combinational fc<IN>_<OUT> datapath: it loads a frame, waits for the datapath to settle, captures the results and drains them.
// Define FC_CTRL_RELU_EN to clamp negative results to zero at capture. When it is undefined, capture is bit-exact.
module fc_frame_ctrl #(
    parameter int WIDTH  = 8,
    parameter int IN     = 256,
    parameter int OUT    = 128,
    parameter int SETTLE = 2,
    localparam int ZW    = 2*WIDTH + $clog2(IN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    input  logic                in_last,
    output logic [IN*WIDTH-1:0] fc_x,
    input  logic [OUT*ZW-1:0]   fc_z,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ZW-1:0]       out_data,
    output logic                out_last,
    output logic                busy,
    output logic                err_len
);
    localparam int CW = (IN > 1) ? $clog2(IN) : 1;
    localparam int IW = (OUT > 1) ? $clog2(OUT) : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {ST_LOAD, ST_WAIT, ST_SETTLE} state_t;

    state_t            state;
    logic [CW-1:0]     load_cnt;
    logic [SW-1:0]     settle_cnt;
    logic              drain_active;
    logic [IW-1:0]     drain_idx;
    logic [IN*WIDTH-1:0] x_q;
    logic [ZW-1:0]     buf_q [OUT];

    logic in_hs, out_hs, drain_done, drain_free, capture, last_slot;

    // NOTE: in_ready is decoded from state and gated by rst, so the bench sees it low for the whole reset cycle.
    assign in_ready   = (state == ST_LOAD) && !rst;
    assign in_hs      = in_valid && in_ready;
    assign out_hs     = drain_active && out_ready;
    assign drain_done = out_hs && (drain_idx == IW'(OUT-1));
    assign drain_free = !drain_active || drain_done;
    assign capture    = (state == ST_SETTLE) && (settle_cnt == SW'(SETTLE-1));
    assign last_slot  = (load_cnt == CW'(IN-1));

    assign fc_x      = x_q;
    assign out_valid = drain_active;
    assign out_data  = buf_q[drain_idx];
    assign out_last  = drain_active && (drain_idx == IW'(OUT-1));
    assign busy      = !((state == ST_LOAD) && (load_cnt == '0) && !drain_active);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_LOAD;
            load_cnt     <= '0;
            settle_cnt   <= '0;
            drain_active <= 1'b0;
            drain_idx    <= '0;
            x_q          <= '0;
            err_len      <= 1'b0;
        end else begin
            err_len <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (in_hs) begin
                        if (in_last && !last_slot) begin
                            load_cnt <= '0;
                            err_len  <= 1'b1;
                        end else begin
                            x_q[load_cnt*WIDTH +: WIDTH] <= in_data;
                            if (last_slot) begin
                                err_len    <= !in_last;
                                settle_cnt <= '0;
                                state      <= drain_free ? ST_SETTLE : ST_WAIT;
                            end else begin
                                load_cnt <= load_cnt + CW'(1);
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (drain_free) begin
                        settle_cnt <= '0;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (capture) begin
                        load_cnt <= '0;
                        state    <= ST_LOAD;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                default: state <= ST_LOAD;
            endcase

            // A capture only happens while the drain is idle, so it cannot conflict with a drain handshake.
            if (capture) begin
                drain_active <= 1'b1;
                drain_idx    <= '0;
            end else if (out_hs) begin
                if (drain_done) begin
                    drain_active <= 1'b0;
                    drain_idx    <= '0;
                end else begin
                    drain_idx <= drain_idx + IW'(1);
                end
            end
        end
    end

    // NOTE: the result buffer has no reset. Its contents are only visible while drain_active is set, and that flag is reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int j = 0; j < OUT; j++) begin
`ifdef FC_CTRL_RELU_EN
                buf_q[j] <= fc_z[j*ZW + ZW - 1] ? '0 : fc_z[j*ZW +: ZW];
`else
                buf_q[j] <= fc_z[j*ZW +: ZW];
`endif
            end
        end
    end
endmodule

// File: doc/fc_frame_ctrl.md
Name: fc_frame_ctrl

Overview:
- Frame sequencer for the combinational fully-connected layer datapath (the fc<IN>_<OUT> blocks).
- Collects one input vector of IN elements from a valid/ready stream and presents it to the datapath as a parallel bus.
- Waits a fixed settle time for the combinational result, captures all OUT results, then streams them out one per handshake.
- Double-buffered: the next frame loads while the previous result drains.

Parameters:
- WIDTH, 8, input element width; result width ZW = 2*WIDTH + $clog2(IN) (derived localparam)
- IN, 256, elements per input frame
- OUT, 128, results per frame
- SETTLE, 2, cycles allowed for datapath propagation (min 1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input element valid
- in_ready  out  1  controller accepts element
- in_data  in  WIDTH  input element
- in_last  in  1  marks final element of frame
- fc_x  out  IN*WIDTH  to datapath; element i at [i*WIDTH +: WIDTH]
- fc_z  in  OUT*ZW  from datapath; result j at [j*ZW +: ZW]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  ZW  result element
- out_last  out  1  high with result OUT-1
- busy  out  1  high when any state other than LOAD with load count 0 and drain idle
- err_len  out  1  one-cycle pulse on frame length error

Behaviour:
- Reset (rst=1 at edge): load FSM to LOAD, load count 0, drain idle, drain index 0. fc_x all zero; out_valid, out_last, err_len, busy = 0; in_ready = 0 while rst high.
- Load FSM states:
  - LOAD: in_ready=1. Each handshake writes in_data to x[count] and increments count.
    - Handshake at count=IN-1 -> SETTLE if drain idle, else WAIT.
  - WAIT: in_ready=0; x full. Go to SETTLE on the cycle drain becomes idle.
  - SETTLE: in_ready=0; fc_x held stable. Counts SETTLE cycles.
    - On the edge ending the last SETTLE cycle: capture all OUT fc_z results into the output buffer, set drain active with index 0, load count 0, go to LOAD.
- Latency: last input handshake at edge E with drain idle -> out_valid high after edge E+SETTLE.
- fc_x is updated only by load handshakes. Elements of the next frame overwrite x progressively; the captured buffer is unaffected.
- Drain: out_valid = drain active. out_data = buffer[index]; out_last = (index==OUT-1).
  - Handshake increments index; at OUT-1 drain goes idle and index returns to 0.
  - out_valid/out_data stable while out_ready=0.
- in_last rules:
  - in_last=1 at count<IN-1: element discarded, count returns to 0, err_len pulses, stay in LOAD (frame dropped).
  - in_last=0 at count=IN-1: element accepted, frame processed normally, err_len pulses.
- Arithmetic: no arithmetic on results other than the optional feature; capture is bit-exact, ZW bits.
- Simultaneous events:
  - Final drain handshake and WAIT in the same cycle: SETTLE starts the next cycle; no bubble beyond that.
  - Capture cannot coincide with an active drain by construction.
- Reset mid-operation discards partial frame and undrained results; returns to reset values the next cycle.

Optional Feature:
- FC_CTRL_RELU_EN defined: at capture, each result is treated as ZW-bit two's complement; negative values (MSB=1) are stored as 0, others stored unchanged.
- Undefined: bit-exact capture, no clamping.

Test Plan:
- Bench stub, IN=4, OUT=2, SETTLE=2, model z[j] = (j+1)*sum(x). Send 1,2,3,4 with in_last on the 4th -> out_data 10 then 20, out_last on 20. out_valid rises exactly 2 cycles after the last input edge.
- Same frame with out_ready held 0 for 5 cycles -> out_data stays 10, out_valid stays 1; then 10, 20 delivered, no loss. Second frame 5,5,5,5 sent during the stall -> enters WAIT, in_ready=0. Outputs 20, 40 follow once the first drain completes.
- in_last on 2nd element -> err_len single pulse, frame dropped. Next frame 1,1,1,1 -> outputs 4, 8.
- Assert rst for one cycle during drain after the first result -> out_valid=0 next cycle, fc_x all zero, in_ready=1 the cycle after rst falls.
- With FC_CTRL_RELU_EN, stub drives z0 = all-ones and z1 = 0x5 -> outputs 0 and 5. Without the macro -> all-ones and 5.
- Defaults with the real fc256_128 datapath: all-zero frame then the 256-element vector 0xa5..0x9d -> drained 128 results match the exp file word-for-word.
